// File: rtl/ram_master_pkg.sv
// Shared widths and FSM state encoding for the RAM burst master.
package ram_master_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN1,
        DRAIN2
    } state_t;

endpackage

// File: rtl/ram_bus_driver.sv
// Tri-state driver and read-sample register for the bidirectional RAM data bus.
module ram_bus_driver #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drive,
    input  logic [DATA_W-1:0] wdata,
    input  logic              sample,
    output logic [DATA_W-1:0] rdata,
    inout  wire  [DATA_W-1:0] bus
);

    // Enable is the registered write strobe, so the bus is released the same
    // cycle the RAM may start returning read data.
    assign bus = drive ? wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (sample) begin
            rdata <= bus;
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst read/write controller for a single-port synchronous RAM with a shared
// bidirectional data bus and one-cycle read latency.
module ram_burst_master
    import ram_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata_p1;
    logic              vld_p1;
    logic              vld_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid && cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_nxt = DRAIN1;
                end
            end
            DRAIN1:  state_nxt = DRAIN2;
            DRAIN2:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Stage p0 -> p1: address/strobe issue. For reads ram_addr is loaded at
    // the handshake so the first address is on the RAM in the first READ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            cnt      <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            wdata_p1 <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            vld_p1 <= (state == READ);
            vld_p2 <= vld_p1;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cnt <= cmd_len;
                        if (cmd_write) begin
                            addr <= cmd_addr;
                        end else begin
                            ram_addr <= cmd_addr;
                            addr     <= cmd_addr + ADDR_ONE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        ram_we   <= 1'b1;
                        ram_addr <= addr;
                        wdata_p1 <= wr_data;
                        addr     <= addr + ADDR_ONE;
                        cnt      <= cnt - LEN_ONE;
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        ram_addr <= addr;
                        addr     <= addr + ADDR_ONE;
                        cnt      <= cnt - LEN_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1 -> p2: bus sample of the RAM read data, reported as rd_valid.
    ram_bus_driver #(
        .DATA_W(DATA_W)
    ) u_bus (
        .clk   (clk),
        .rst   (rst),
        .drive (ram_we),
        .wdata (wdata_p1),
        .sample(vld_p1),
        .rdata (rd_data),
        .bus   (ram_data)
    );

    assign rd_valid = vld_p2;

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator-side controller for the timing module's single-port synchronous RAM (15-bit address, 8-bit bidirectional data bus, write-enable; synchronous read that returns data the cycle after the address is presented).
- Accepts burst read/write commands from a host through a valid/ready handshake.
- Drives the RAM address, write-enable and tri-state data bus.
- Streams write data in and read data out at one beat per cycle.
- Sits between the timing sequencer logic and the RAM instance.

## Interface
- ADDR_W, 15, RAM address width
- DATA_W, 8, RAM data width
- LEN_W, 8, burst length field width (beats = cmd_len + 1, max 256)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller accepts command (high only in IDLE)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wr_data  in  DATA_W  write beat data
- wr_valid  in  1  write beat available
- wr_ready  out  1  controller takes write beat (high only in WRITE)
- rd_data  out  DATA_W  read beat data
- rd_valid  out  1  read beat valid for one cycle; no backpressure
- busy  out  1  high whenever state != IDLE
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_data  inout  DATA_W  RAM data bus; driven only while ram_we = 1, else high-Z

## Operation
- States are IDLE, WRITE, READ, DRAIN1 and DRAIN2.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: load the address counter from cmd_addr and the beat counter from cmd_len.
  - Go to WRITE if cmd_write = 1, else READ.
- WRITE:
  - wr_ready = 1.
  - Each wr_valid & wr_ready edge registers ram_we = 1, ram_addr = current address and the data register = wr_data for the next cycle. The RAM commits the beat at the edge after that.
  - If there is no handshake, ram_we = 0 the next cycle (stall; bus released).
  - Address increments per beat; beat counter decrements.
  - The handshake on the beat with counter = 0 returns the state to IDLE.
  - The final we pulse occurs in the first IDLE cycle.
- READ:
  - One address is issued per cycle with ram_we = 0, for cmd_len + 1 cycles, then the state goes to DRAIN1.
  - Bus data is sampled at the end of the cycle after each address is issued.
  - rd_valid is asserted in the following cycle.
- DRAIN1, DRAIN2: one cycle each. The last rd_valid occurs in DRAIN2, then the state returns to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0x7FFF + 1 = 0x0000 inside a burst.
- rd_valid beats appear in address order, contiguous, exactly cmd_len + 1 of them.
- Reset (async, any state):
  - state = IDLE; ram_we = 0; ram_addr = 0; ram_data high-Z.
  - rd_valid = 0; rd_data = 0; busy = 0; cmd_ready = 1; wr_ready = 0.
  - An in-flight burst is abandoned; no partial beats are reported after reset deasserts.

## Timing
- Command accepted at edge E (end of cycle c).
- Write path:
  - WRITE active in cycle c+1.
  - A beat accepted at the end of cycle w has ram_we = 1 in w+1.
  - The RAM stores it at the end of w+1.
- Read path:
  - First address is presented in c+1.
  - RAM data is on the bus in c+2.
  - First rd_valid is in c+3 (3 cycles after the handshake).
  - Last rd_valid is in c+len+3.
  - IDLE is reached in c+len+4.
- Throughput is 1 beat/cycle in both directions when wr_valid is held high.
- The master's bus driver enable is exactly the registered ram_we, so it never drives while the RAM drives.

## Structure
- Package ram_master_pkg holds:
  - ADDR_W, DATA_W and LEN_W defaults.
  - The state enum (IDLE, WRITE, READ, DRAIN1, DRAIN2).
- Sub-module ram_bus_driver holds the tri-state output buffer plus the input sample register for ram_data. It keeps the inout handling isolated from the FSM.

## Test plan
- Write burst: addr 0x0010, len 3, data A0 A1 A2 A3 with wr_valid held high, then read the same burst -> rd_data A0 A1 A2 A3 on 4 consecutive rd_valid cycles, first one 3 cycles after the read handshake.
- Wrap-around: write 0x55, 0x66 at 0x7FFF (len 1) -> ram_addr sequence 0x7FFF, 0x0000; reading 0x0000 returns 0x66.
- Write stall: drop wr_valid for 2 cycles mid-burst -> ram_we low for those cycles, no address advance, and a later read-back matches the data exactly.
- Uninitialised read: single read (len 0) of 0x1234 after power-up -> rd_data 0x00, exactly one rd_valid pulse.
- Reset mid-read: assert rst during a READ of len 7 -> all outputs reach their reset values immediately, no rd_valid after release, and the next command works normally.
- Bus check: monitor ram_data -> the master never drives while ram_we = 0; ram_data is never X during any read-sample cycle.
